// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM states and port index for the external SRAM arbiter.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN.
package sram_arb_pkg;

    localparam int ADR_W = 18;
    localparam int DAT_W = 16;
    localparam int BE_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational A/B grant; round-robin last-grant pointer when
// SRAM_ARB_ROUND_ROBIN_EN is defined, fixed A priority otherwise.
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  a_req_i,
    input  logic  b_req_i,
    input  logic  take_i,
    output port_t gnt_o
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    port_t last_q;

    always_comb begin
        gnt_o = PORT_A;
        if (b_req_i && (!a_req_i || last_q == PORT_A))
            gnt_o = PORT_B;
    end

    // Reset to B so that A wins the first contended grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last_q <= PORT_B;
        else if (take_i)
            last_q <= gnt_o;
    end
`else
    logic unused_ok;

    assign unused_ok = ^{clk_i, rst_i, take_i};

    always_comb begin
        gnt_o = PORT_A;
        if (b_req_i && !a_req_i)
            gnt_o = PORT_B;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for the 256Kx16 async SRAM.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin grant).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             greset,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [ADR_W-1:0] a_addr,
    input  logic [DAT_W-1:0] a_wdata,
    input  logic [BE_W-1:0]  a_be,
    output logic             a_ack,
    output logic [DAT_W-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [ADR_W-1:0] b_addr,
    input  logic [DAT_W-1:0] b_wdata,
    input  logic [BE_W-1:0]  b_be,
    output logic             b_ack,
    output logic [DAT_W-1:0] b_rdata,
    output logic             RAMCS,
    output logic             RAMOE,
    output logic             RAMWE,
    output logic             RAMLB,
    output logic             RAMUB,
    output logic [ADR_W-1:0] ADR,
    inout  wire  [DAT_W-1:0] DAT
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t           state_q;
    port_t            port_q;
    port_t            gnt;
    logic             we_q;
    logic [BE_W-1:0]  be_q;
    logic [DAT_W-1:0] wdata_q;
    logic [2:0]       cnt_q;
    logic [ADR_W-1:0] adr_q;
    logic             cs_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
    logic             dat_oe_q;
    logic             a_ack_q, b_ack_q;
    logic [DAT_W-1:0] a_rdata_q, b_rdata_q;
    logic             any_req;
    logic             sel_we;
    logic [ADR_W-1:0] sel_addr;
    logic [DAT_W-1:0] sel_wdata;
    logic [BE_W-1:0]  sel_be;
    logic [DAT_W-1:0] rd_data;

    assign any_req = a_req | b_req;

    sram_arb_grant u_grant (
        .clk_i   (clk),
        .rst_i   (greset),
        .a_req_i (a_req),
        .b_req_i (b_req),
        .take_i  (state_q == IDLE && any_req),
        .gnt_o   (gnt)
    );

    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        sel_be    = a_be;
        if (gnt == PORT_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_be    = b_be;
        end
    end

    // Disabled bytes read back as zero regardless of what the bus holds.
    assign rd_data = DAT & {{8{be_q[1]}}, {8{be_q[0]}}};

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            state_q   <= IDLE;
            port_q    <= PORT_A;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            adr_q     <= '0;
            cs_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            dat_oe_q  <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: if (any_req) begin
                    port_q   <= gnt;
                    we_q     <= sel_we;
                    be_q     <= sel_be;
                    wdata_q  <= sel_wdata;
                    adr_q    <= sel_addr;
                    cs_n_q   <= 1'b0;
                    lb_n_q   <= !sel_be[0];
                    ub_n_q   <= !sel_be[1];
                    dat_oe_q <= sel_we;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    cnt_q   <= WS;
                    oe_n_q  <= we_q;
                    we_n_q  <= !we_q;
                    state_q <= STROBE;
                end
                STROBE: if (cnt_q == 3'd0) begin
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    state_q <= HOLD;
                    if (port_q == PORT_A) begin
                        a_ack_q <= 1'b1;
                        if (!we_q) a_rdata_q <= rd_data;
                    end else begin
                        b_ack_q <= 1'b1;
                        if (!we_q) b_rdata_q <= rd_data;
                    end
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
                HOLD: begin
                    cs_n_q   <= 1'b1;
                    lb_n_q   <= 1'b1;
                    ub_n_q   <= 1'b1;
                    dat_oe_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DAT     = dat_oe_q ? wdata_q : {DAT_W{1'bz}};
    assign ADR     = adr_q;
    assign RAMCS   = cs_n_q;
    assign RAMOE   = oe_n_q;
    assign RAMWE   = we_n_q;
    assign RAMLB   = lb_n_q;
    assign RAMUB   = ub_n_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a simple SRAM read model.
// Build with +define+SRAM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        greset;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [17:0] a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic [1:0]  a_be = '0, b_be = '0;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic        RAMCS, RAMOE, RAMWE, RAMLB, RAMUB;
    logic [17:0] ADR;
    tri0  [15:0] DAT;

    int total = 0;
    int bad   = 0;

    int          lat, oe_lo, we_lo, cs_lo, dat_bad, ack_oth;
    logic [1:0]  lbub;
    logic [15:0] rd_got;
    logic        ack_after, cs_after;

    always #5 clk = ~clk;

    // SRAM model: returns ADR[15:0] while read-strobed
    assign DAT = (!RAMCS && !RAMOE) ? ADR[15:0] : 16'hzzzz;

    sram_arbiter #(.WAIT_STATES(1)) dut (
        .clk(clk), .greset(greset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_be(a_be), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_be(b_be), .b_ack(b_ack), .b_rdata(b_rdata),
        .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE), .RAMLB(RAMLB),
        .RAMUB(RAMUB), .ADR(ADR), .DAT(DAT)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        greset = 1'b1;
        repeat (2) @(negedge clk);
        greset = 1'b0;
    endtask

    task automatic run_req(input bit pb, input bit we, input logic [17:0] addr,
                           input logic [15:0] wd, input logic [1:0] be);
        @(negedge clk);
        if (pb) begin
            b_we = we; b_addr = addr; b_wdata = wd; b_be = be; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wd; a_be = be; a_req = 1'b1;
        end
        lat = 0; oe_lo = 0; we_lo = 0; cs_lo = 0; dat_bad = 0; ack_oth = 0;
        lbub = 2'b11; rd_got = '0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (!RAMOE) oe_lo++;
            if (!RAMWE) we_lo++;
            if (!RAMCS) begin
                cs_lo++;
                lbub = {RAMLB, RAMUB};
                if (we && DAT !== wd) dat_bad++;
            end
            if (pb ? a_ack : b_ack) ack_oth++;
            if (pb ? b_ack : a_ack) begin
                lat = i;
                rd_got = pb ? b_rdata : a_rdata;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
        ack_after = a_ack | b_ack;
        cs_after  = RAMCS;
    endtask

    initial begin
        int         n_ack, n_both, c0, c1;
        logic [3:0] seq;
        bit         seen;

        greset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_strobes", {RAMCS, RAMOE, RAMWE, RAMLB, RAMUB}, 5'h1F);
        check("rst_adr", ADR, 18'h0);
        check("rst_dat_z", DAT, 16'h0);
        greset = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack) n_ack++;
        end
        check("idle_no_ack", n_ack, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 32'h0);

        // A read, full word
        run_req(1'b0, 1'b0, 18'h12345, 16'h0, 2'b11);
        check("a_rd_lat", lat, 4);
        check("a_rd_oe_lo", oe_lo, 2);
        check("a_rd_we_lo", we_lo, 0);
        check("a_rd_cs_lo", cs_lo, 4);
        check("a_rd_data", rd_got, 16'h2345);
        check("a_rd_ack_once", ack_after, 1'b0);
        check("a_rd_cs_rel", cs_after, 1'b1);
        check("a_rd_no_b", ack_oth, 0);

        // B write, high byte only
        run_req(1'b1, 1'b1, 18'h00010, 16'hBEEF, 2'b10);
        check("b_wr_lat", lat, 4);
        check("b_wr_we_lo", we_lo, 2);
        check("b_wr_oe_lo", oe_lo, 0);
        check("b_wr_lbub", lbub, 2'b10);
        check("b_wr_dat", dat_bad, 0);
        check("b_wr_cs_lo", cs_lo, 4);
        check("b_wr_ack_once", ack_after, 1'b0);
        check("b_wr_dat_rel", DAT, 16'h0);
        check("b_wr_adr", ADR, 18'h00010);

        // A read, low byte only
        run_req(1'b0, 1'b0, 18'h0ABCD, 16'h0, 2'b01);
        check("a_be01_data", rd_got, 16'h00CD);
        check("a_be01_lbub", lbub, 2'b01);

        // Both ports hold reads continuously
        do_reset();
        a_we = 0; a_addr = 18'h00011; a_be = 2'b11;
        b_we = 0; b_addr = 18'h00022; b_be = 2'b11;
        a_req = 1'b1; b_req = 1'b1;
        n_ack = 0; n_both = 0; seq = '0; c0 = 0; c1 = 0;
        for (int i = 1; i <= 40 && n_ack < 4; i++) begin
            @(posedge clk); #1;
            if (a_ack && b_ack) n_both++;
            if (a_ack || b_ack) begin
                seq[n_ack] = b_ack;
                if (n_ack == 0) c0 = i;
                if (n_ack == 1) c1 = i;
                n_ack++;
            end
        end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        check("both_n_ack", n_ack, 4);
        check("both_one_ack", n_both, 0);
        check("both_period", c1 - c0, 5);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        check("both_seq", seq, 4'b1010);
        check("both_b_rdata", b_rdata, 16'h0022);
`else
        check("both_seq", seq, 4'b0000);
        check("both_b_rdata", b_rdata, 16'h0000);
`endif
        check("both_a_rdata", a_rdata, 16'h0011);
        repeat (8) @(negedge clk);

        // Reset during the write strobe
        b_we = 1'b1; b_addr = 18'h00033; b_wdata = 16'h5A5A; b_be = 2'b11;
        b_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (!RAMWE) seen = 1'b1;
        end
        check("mid_we_seen", seen, 1'b1);
        #2;
        greset = 1'b1;
        #1;
        check("mid_rst_we", RAMWE, 1'b1);
        check("mid_rst_cs", RAMCS, 1'b1);
        check("mid_rst_dat_z", DAT, 16'h0);
        b_req = 1'b0;
        @(negedge clk);
        greset = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack) n_ack++;
        end
        check("mid_rst_no_ack", n_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
